// File: rtl/pll_lock_sequencer.sv
// PLL start-up and lock supervisor: pulses the PLL reset, waits for a stable
// synchronized lock, then releases the system reset; counts losses of lock.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   PLL_RESET | pll_rst held high for PLL_RST_CYCLES
//   WAIT_LOCK | waiting for locked_s, bounded by LOCK_TIMEOUT_CYCLES
//   HOLD      | locked_s must stay high for LOCK_HOLD_CYCLES
//   RUN       | system reset released, lock supervised
module pll_lock_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_HOLD_CYCLES    = 1000,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int CNT_W               = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             clear_stats,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] relock_count,
  output logic             lock_timeout
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_HOLD_CYCLES) ? PLL_RST_CYCLES : LOCK_HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(LOCK_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;

  assign locked_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Outputs are updated on the same edge as the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sys_rst_n    <= 1'b0;
      ready        <= 1'b0;
      relock_count <= '0;
      lock_timeout <= 1'b0;
    end else begin
      if (clear_stats) begin
        relock_count <= '0;
        lock_timeout <= 1'b0;
      end
      case (state)
        PLL_RESET: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= HOLD;
            cnt   <= '0;
          end else if (cnt == TMO_LAST) begin
            state        <= PLL_RESET;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            lock_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            // A simultaneous clear still records this event.
            if (clear_stats) begin
              relock_count <= CNT_W'(1);
            end else if (relock_count != CNT_MAX) begin
              relock_count <= relock_count + CNT_W'(1);
            end
          end
        end
        default: begin
          state     <= PLL_RESET;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       clear_stats;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] relock_count;
  logic       lock_timeout;

  int tests;
  int fails;

  pll_lock_sequencer #(
    .SYNC_STAGES(2),
    .PLL_RST_CYCLES(4),
    .LOCK_HOLD_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .clear_stats(clear_stats),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .relock_count(relock_count),
    .lock_timeout(lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pll_locked = 1'b0;
    clear_stats = 1'b0;
    tick(3);
    tests++;
    if (pll_rst !== 1'b1) begin fails++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
    tests++;
    if (sys_rst_n !== 1'b0) begin fails++; $display("FAIL reset_sys_rst_n got %b want 0", sys_rst_n); end
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready); end
    tests++;
    if (relock_count !== 8'd0) begin fails++; $display("FAIL reset_relock_count got %0d want 0", relock_count); end
    tests++;
    if (lock_timeout !== 1'b0) begin fails++; $display("FAIL reset_lock_timeout got %b want 0", lock_timeout); end
  endtask

  // Releases rst_n and walks through a full lock; ends in RUN.
  task automatic test_clean_start();
    int n;
    pll_locked = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n != 4) begin fails++; $display("FAIL clean_pll_rst_width got %0d want 4", n); end
    tick(10);
    pll_locked = 1'b1;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n < 10 || n > 12) begin fails++; $display("FAIL clean_lock_latency got %0d want 11", n); end
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL clean_ready got %b want 1", ready); end
    tests++;
    if (relock_count !== 8'd0) begin fails++; $display("FAIL clean_relock_count got %0d want 0", relock_count); end
    tests++;
    if (lock_timeout !== 1'b0) begin fails++; $display("FAIL clean_lock_timeout got %b want 0", lock_timeout); end
  endtask

  // Drops lock in RUN; leaves the DUT in WAIT_LOCK with pll_locked low.
  task automatic test_loss_in_run();
    int n;
    pll_locked = 1'b0;
    n = 0;
    while (sys_rst_n !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n < 2 || n > 4) begin fails++; $display("FAIL loss_latency got %0d want 3", n); end
    tests++;
    if (relock_count !== 8'd1) begin fails++; $display("FAIL loss_relock_count got %0d want 1", relock_count); end
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL loss_ready got %b want 0", ready); end
    tests++;
    if (pll_rst !== 1'b0) begin fails++; $display("FAIL loss_pll_rst got %b want 0", pll_rst); end
  endtask

  task automatic test_glitch_hold();
    int n;
    int early;
    early = 0;
    pll_locked = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sys_rst_n !== 1'b0) early++;
    end
    pll_locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (sys_rst_n !== 1'b0) early++;
    end
    pll_locked = 1'b1;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (early != 0) begin fails++; $display("FAIL glitch_early_release got %0d high samples want 0", early); end
    tests++;
    if (n < 10 || n > 12) begin fails++; $display("FAIL glitch_restart_latency got %0d want 11", n); end
    tests++;
    if (relock_count !== 8'd1) begin fails++; $display("FAIL glitch_relock_count got %0d want 1", relock_count); end
  endtask

  task automatic relock_cycle(output int fall_lat);
    int n;
    pll_locked = 1'b0;
    fall_lat = 0;
    while (sys_rst_n !== 1'b0 && fall_lat < 100) begin
      @(negedge clk);
      fall_lat++;
    end
    pll_locked = 1'b1;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_clear_collision();
    int lat;
    for (int i = 0; i < 6; i++) relock_cycle(lat);
    tests++;
    if (relock_count !== 8'd7) begin fails++; $display("FAIL collision_precount got %0d want 7", relock_count); end
    pll_locked = 1'b0;
    tick(2);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    tests++;
    if (sys_rst_n !== 1'b0) begin fails++; $display("FAIL collision_sys_rst_n got %b want 0", sys_rst_n); end
    tests++;
    if (relock_count !== 8'd1) begin fails++; $display("FAIL collision_count got %0d want 1", relock_count); end
    pll_locked = 1'b1;
    tick(15);
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL collision_relock_ready got %b want 1", ready); end
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    tests++;
    if (relock_count !== 8'd0) begin fails++; $display("FAIL lone_clear_count got %0d want 0", relock_count); end
  endtask

  task automatic test_saturation();
    int lat;
    int bad_lat;
    bad_lat = 0;
    for (int i = 0; i < 300; i++) begin
      relock_cycle(lat);
      if (lat < 2 || lat > 4) bad_lat++;
      if (i == 0) begin
        tests++;
        if (relock_count !== 8'd1) begin fails++; $display("FAIL sat_first_count got %0d want 1", relock_count); end
      end
      if (i == 253) begin
        tests++;
        if (relock_count !== 8'd254) begin fails++; $display("FAIL sat_254_count got %0d want 254", relock_count); end
      end
    end
    tests++;
    if (bad_lat != 0) begin fails++; $display("FAIL sat_fall_latency got %0d bad drops want 0", bad_lat); end
    tests++;
    if (relock_count !== 8'd255) begin fails++; $display("FAIL sat_final_count got %0d want 255", relock_count); end
  endtask

  task automatic test_timeout();
    int n;
    int sys_high;
    int early_flag;
    sys_high = 0;
    early_flag = 0;
    pll_locked = 1'b0;
    n = 0;
    while (sys_rst_n !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (pll_rst !== 1'b1 && n < 200) begin
      if (lock_timeout !== 1'b0) early_flag++;
      if (sys_rst_n !== 1'b0) sys_high++;
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 32) begin fails++; $display("FAIL timeout_first_wait got %0d want 32", n); end
    tests++;
    if (early_flag != 0) begin fails++; $display("FAIL timeout_flag_early got %0d samples want 0", early_flag); end
    tests++;
    if (lock_timeout !== 1'b1) begin fails++; $display("FAIL timeout_flag_on_rise got %b want 1", lock_timeout); end
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (pll_rst === 1'b1 && n < 100) begin
        if (sys_rst_n !== 1'b0) sys_high++;
        n++;
        @(negedge clk);
      end
      tests++;
      if (n != 4) begin fails++; $display("FAIL timeout_pulse_%0d got %0d want 4", r, n); end
      n = 0;
      while (pll_rst !== 1'b1 && n < 200) begin
        if (sys_rst_n !== 1'b0) sys_high++;
        n++;
        @(negedge clk);
      end
      tests++;
      if (n != 32) begin fails++; $display("FAIL timeout_gap_%0d got %0d want 32", r, n); end
    end
    tests++;
    if (lock_timeout !== 1'b1) begin fails++; $display("FAIL timeout_sticky got %b want 1", lock_timeout); end
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    tests++;
    if (lock_timeout !== 1'b0) begin fails++; $display("FAIL timeout_clear got %b want 0", lock_timeout); end
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (pll_rst !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (lock_timeout !== 1'b1) begin fails++; $display("FAIL timeout_reset_again got %b want 1", lock_timeout); end
    tests++;
    if (sys_high != 0) begin fails++; $display("FAIL timeout_sys_rst_n_high got %0d samples want 0", sys_high); end
  endtask

  task automatic check_async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (pll_rst !== 1'b1) begin fails++; $display("FAIL %s_pll_rst got %b want 1", tag, pll_rst); end
    tests++;
    if (sys_rst_n !== 1'b0 || ready !== 1'b0) begin
      fails++; $display("FAIL %s_sys_rst got sys_rst_n=%b ready=%b want 0 0", tag, sys_rst_n, ready);
    end
    tests++;
    if (relock_count !== 8'd0 || lock_timeout !== 1'b0) begin
      fails++; $display("FAIL %s_stats got count=%0d flag=%b want 0 0", tag, relock_count, lock_timeout);
    end
    tick(3);
  endtask

  task automatic test_reset_mid();
    int n;
    pll_locked = 1'b1;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (sys_rst_n !== 1'b1) begin fails++; $display("FAIL midreset_reach_run got %b want 1", sys_rst_n); end
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    tick(6);
    tests++;
    if (relock_count === 8'd0 || lock_timeout !== 1'b1) begin
      fails++; $display("FAIL midreset_pre_stats got count=%0d flag=%b want nonzero 1", relock_count, lock_timeout);
    end
    check_async_reset("hold_reset");
    test_clean_start();
    check_async_reset("run_reset");
    test_clean_start();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_clean_start();
    test_loss_in_run();
    test_glitch_hold();
    test_clear_collision();
    test_saturation();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
